// File: rtl/adder_tree_pkg.sv
// Shared types and helpers for the pipelined adder tree: accumulator FSM
// states, the beat-count width and a constant-foldable log2.
package adder_tree_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } acc_state_e;

  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = v; x > 1; x = x >> 1) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: N pairwise sign-extending adders,
// with the beat sideband (valid/first/last) carried alongside the data.
module adder_tree_level #(
  parameter int unsigned N    = 1,
  parameter int unsigned IN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [2*N*IN_W-1:0]     in_data,
  output logic                    out_valid,
  output logic                    out_first,
  output logic                    out_last,
  output logic [N*(IN_W+1)-1:0]   out_data
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      out_first <= in_valid & in_first;
      out_last  <= in_valid & in_last;
      for (int unsigned i = 0; i < N; i++) begin
        out_data[i*(IN_W+1) +: (IN_W+1)] <=
          {in_data[(2*i+1)*IN_W-1], in_data[2*i*IN_W +: IN_W]} +
          {in_data[(2*i+2)*IN_W-1], in_data[(2*i+1)*IN_W +: IN_W]};
      end
    end
  end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree feeding a multi-beat accumulator with a
// registered result; PIPELINED_ADDER_TREE_SAT_EN selects clamping of out_sum.
module pipelined_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int unsigned N_IN  = 8,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned OUT_W = 22
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [N_IN*IN_W-1:0]   in_data,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_sum,
  output logic [CNT_W-1:0]       out_cnt,
  output logic                   out_sat
);

  localparam int unsigned LEVELS = log2(N_IN);
  localparam int unsigned TW     = IN_W + LEVELS;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned NO = N_IN >> (k + 1);
    localparam int unsigned WI = IN_W + k;

    logic [2*NO*WI-1:0]   din;
    logic [NO*(WI+1)-1:0] dout;
    logic                 vi, fi, li;
    logic                 vo, fo, lo;

    if (k == 0) begin : g_src
      assign din = in_data;
      assign vi  = in_valid;
      assign fi  = in_first;
      assign li  = in_last;
    end else begin : g_chain
      assign din = g_lvl[k-1].dout;
      assign vi  = g_lvl[k-1].vo;
      assign fi  = g_lvl[k-1].fo;
      assign li  = g_lvl[k-1].lo;
    end

    adder_tree_level #(
      .N    (NO),
      .IN_W (WI)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vi),
      .in_first  (fi),
      .in_last   (li),
      .in_data   (din),
      .out_valid (vo),
      .out_first (fo),
      .out_last  (lo),
      .out_data  (dout)
    );
  end

  logic [TW-1:0]            tsum;
  logic                     tv, tf, tl;
  logic signed [ACC_W-1:0]  beat_ext;

  assign tsum     = g_lvl[LEVELS-1].dout;
  assign tv       = g_lvl[LEVELS-1].vo;
  assign tf       = g_lvl[LEVELS-1].fo;
  assign tl       = g_lvl[LEVELS-1].lo;
  assign beat_ext = ACC_W'($signed(tsum));

  acc_state_e               state, state_nxt;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     pend, pend_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACC_IDLE;
      acc   <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    pend_nxt  = 1'b0;
    if (tv) begin
      if (tf || state == ACC_IDLE) begin
        acc_nxt = beat_ext;
        cnt_nxt = CNT_W'(1);
      end else begin
        acc_nxt = acc + beat_ext;
        cnt_nxt = (cnt == '1) ? cnt : cnt + CNT_W'(1);
      end
      state_nxt = tl ? ACC_IDLE : ACC_RUN;
      pend_nxt  = tl;
    end
  end

  // The result is formatted from the completed accumulator one cycle after the
  // last beat lands, giving LEVELS+1 cycles from input to out_valid.
  logic [OUT_W-1:0] sum_c;
  logic             sat_c;

`ifdef PIPELINED_ADDER_TREE_SAT_EN
  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    sum_c = acc[OUT_W-1:0];
    sat_c = 1'b0;
    if (acc > SMAX) begin
      sum_c = SMAX[OUT_W-1:0];
      sat_c = 1'b1;
    end else if (acc < SMIN) begin
      sum_c = SMIN[OUT_W-1:0];
      sat_c = 1'b1;
    end
  end
`else
  always_comb begin
    sum_c = acc[OUT_W-1:0];
    sat_c = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= pend;
      if (pend) begin
        out_sum <= sum_c;
        out_cnt <= cnt;
        out_sat <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench for pipelined_adder_tree (N_IN=8, IN_W=16, OUT_W=22).
module tb_pipelined_adder_tree;

  localparam int N_IN = 8;
  localparam int IN_W = 16;
  localparam int OUT_W = 22;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid, in_first, in_last;
  logic [N_IN*IN_W-1:0]  in_data;
  logic                  out_valid;
  logic [OUT_W-1:0]      out_sum;
  logic [15:0]           out_cnt;
  logic                  out_sat;

  pipelined_adder_tree #(
    .N_IN  (N_IN),
    .IN_W  (IN_W),
    .ACC_W (32),
    .OUT_W (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [OUT_W-1:0] sum;
    int                      cnt;
    bit                      sat;
    int                      cyc;
  } res_t;

  res_t q[$];

  always @(negedge clk) begin : collect
    res_t r;
    if (out_valid === 1'b1) begin
      r.sum = out_sum;
      r.cnt = int'(out_cnt);
      r.sat = out_sat;
      r.cyc = cyc;
      q.push_back(r);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int val, input int step, input bit f, input bit l);
    for (int i = 0; i < N_IN; i++) in_data[i*IN_W +: IN_W] = 16'(val + i*step);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    string  name;
    int     beats;
    int     val;
    int     step;
    longint exp_sum;
    int     exp_cnt;
    bit     exp_sat;
  } vec_t;

  vec_t vecs[7];
  int   t0;

  initial begin
    vecs[0] = '{"ones_1beat",      1,      1, 0,        8, 1, 1'b0};
    vecs[1] = '{"neg_max_4beat",   4, -32768, 0, -1048576, 4, 1'b0};
`ifdef PIPELINED_ADDER_TREE_SAT_EN
    vecs[2] = '{"pos_max_9beat",   9,  32767, 0,  2097151, 9, 1'b1};
`else
    vecs[2] = '{"pos_max_9beat",   9,  32767, 0, -1835080, 9, 1'b0};
`endif
    vecs[3] = '{"minus1_2beat",    2,     -1, 0,      -16, 2, 1'b0};
    vecs[4] = '{"hundred_3beat",   3,    100, 0,     2400, 3, 1'b0};
    vecs[5] = '{"ramp_1to8",       1,      1, 1,       36, 1, 1'b0};
    vecs[6] = '{"ramp_m4to3",      1,     -4, 1,       -4, 1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_data = '0;
    idle(3);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_out_sum",   longint'(out_sum), 0);
    chk("reset_out_cnt",   longint'(out_cnt), 0);
    chk("reset_out_sat",   longint'(out_sat), 0);
    rst_n = 1'b1;
    idle(2);

    foreach (vecs[v]) begin
      q.delete();
      for (int b = 0; b < vecs[v].beats; b++)
        send(vecs[v].val, vecs[v].step, b == 0, b == vecs[v].beats - 1);
      idle(12);
      chk({vecs[v].name, "_count"}, q.size(), 1);
      if (q.size() >= 1) begin
        chk({vecs[v].name, "_sum"}, longint'(q[0].sum), vecs[v].exp_sum);
        chk({vecs[v].name, "_cnt"}, q[0].cnt, vecs[v].exp_cnt);
        chk({vecs[v].name, "_sat"}, q[0].sat, vecs[v].exp_sat);
      end
    end

    // latency: beat captured at edge t -> out_valid after edge t+4
    q.delete();
    send(1, 0, 1'b1, 1'b1);
    t0 = cyc;
    idle(12);
    chk("latency_count", q.size(), 1);
    if (q.size() >= 1) chk("latency_cycles", q[0].cyc - t0, 4);

    // back-to-back single-beat sums
    q.delete();
    send(2, 0, 1'b1, 1'b1);
    send(3, 0, 1'b1, 1'b1);
    idle(12);
    chk("b2b_count", q.size(), 2);
    if (q.size() >= 2) begin
      chk("b2b_sum0", longint'(q[0].sum), 16);
      chk("b2b_sum1", longint'(q[1].sum), 24);
      chk("b2b_consecutive", q[1].cyc - q[0].cyc, 1);
    end

    // reset mid-run drops in-flight beats
    q.delete();
    send(7, 0, 1'b1, 1'b0);
    send(7, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send(5, 0, 1'b1, 1'b1);
    idle(12);
    chk("rst_mid_count", q.size(), 1);
    if (q.size() >= 1) begin
      chk("rst_mid_sum", longint'(q[0].sum), 40);
      chk("rst_mid_cnt", q[0].cnt, 1);
    end

    // first mid-run restarts the sum
    q.delete();
    send(1, 0, 1'b1, 1'b0);
    send(1, 0, 1'b0, 1'b0);
    send(2, 0, 1'b1, 1'b0);
    send(2, 0, 1'b0, 1'b1);
    idle(12);
    chk("restart_count", q.size(), 1);
    if (q.size() >= 1) begin
      chk("restart_sum", longint'(q[0].sum), 32);
      chk("restart_cnt", q[0].cnt, 2);
    end
    idle(5);
    chk("hold_sum",   longint'($signed(out_sum)), 32);
    chk("hold_cnt",   longint'(out_cnt), 2);
    chk("hold_valid", longint'(out_valid), 0);

    // gaps and first/last with in_valid low are ignored
    q.delete();
    send(10, 0, 1'b1, 1'b0);
    in_first = 1'b1; in_last = 1'b1;
    idle(3);
    in_first = 1'b0; in_last = 1'b0;
    send(10, 0, 1'b0, 1'b1);
    idle(12);
    chk("gap_count", q.size(), 1);
    if (q.size() >= 1) begin
      chk("gap_sum", longint'(q[0].sum), 160);
      chk("gap_cnt", q[0].cnt, 2);
    end

    // a beat without first in idle starts a new sum
    q.delete();
    send(4, 0, 1'b0, 1'b1);
    idle(12);
    chk("idle_nofirst_count", q.size(), 1);
    if (q.size() >= 1) begin
      chk("idle_nofirst_sum", longint'(q[0].sum), 32);
      chk("idle_nofirst_cnt", q[0].cnt, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
